// File: rtl/simm_pkg.sv
// rtl/simm_pkg.sv - shared types and sizing helpers for the SIMM controller/responder pair
package simm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ROW_OPEN   = 2'd1,
        ST_COL_ACTIVE = 2'd2,
        ST_REFRESH    = 2'd3
    } simm_state_e;

    localparam int LANES     = 4;
    localparam int LANE_BITS = 8;

    // Multiplexed address bus carries whichever of row/column is wider.
    function automatic int addr_width(input int row_bits, input int col_bits);
        return (row_bits > col_bits) ? row_bits : col_bits;
    endfunction

    function automatic int bank_width(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/simm_read_pipe.sv
// rtl/simm_read_pipe.sv - fixed-latency read return pipe with hold register and flush
module simm_read_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0] r_vld;
    logic [WIDTH-1:0] r_dat [DEPTH];
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Shift the read through DEPTH stages; the hold register keeps the word
    // until CAS rises, and keeps rdata stable after valid drops.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_vld   <= '0;
            for (int i = 0; i < DEPTH; i++) r_dat[i] <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_vld   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_vld[0] <= i_valid;
            r_dat[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
            if (r_vld[DEPTH-1]) begin
                r_valid <= 1'b1;
                r_data  <= r_dat[DEPTH-1];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/simm_dram_responder.sv
// rtl/simm_dram_responder.sv - FPM DRAM SIMM responder with CBR refresh and violation tracking
module simm_dram_responder
    import simm_pkg::*;
#(
    parameter int ROW_BITS      = 4,
    parameter int COL_BITS      = 4,
    parameter int BANKS         = 4,
    parameter int READ_LATENCY  = 2,
    parameter int TRAS_MIN      = 3,
    parameter int REFRESH_LIMIT = 1024,
    localparam int MA_BITS      = addr_width(ROW_BITS, COL_BITS)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [BANKS-1:0]   i_ras,
    input  logic [3:0]         i_cas,
    input  logic               i_we,
    input  logic [MA_BITS-1:0] i_ma,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    output logic               o_rdata_valid,
    output logic [15:0]        o_refresh_count,
    output logic               o_refresh_overdue,
    output logic               o_protocol_error,
    input  logic               i_err_clear
);

    localparam int BANK_W = bank_width(BANKS);
    localparam int IDX_W  = BANK_W + ROW_BITS + COL_BITS;
    localparam int WORDS  = BANKS << (ROW_BITS + COL_BITS);
    localparam int TRAS_W = $clog2(TRAS_MIN + 1);
    localparam int IVL_W  = $clog2(REFRESH_LIMIT + 1);

    simm_state_e         r_state, w_next_state;
    logic [BANKS-1:0]    r_ras_prev;
    logic [3:0]          r_cas_prev;
    logic [BANK_W-1:0]   r_bank;
    logic [ROW_BITS-1:0] r_row;
    logic [TRAS_W-1:0]   r_tras;
    logic                r_cas_only;
    logic [15:0]         r_refresh_count;
    logic [IVL_W-1:0]    r_interval;
    logic                r_ref_seen;
    logic                r_overdue;
    logic                r_perr;
    logic [31:0]         r_mem [WORDS];

    logic [BANKS-1:0]    w_ras_fall, w_ras_rise, w_bank_onehot;
    logic [3:0]          w_cas_fall;
    logic                w_cas_all_high, w_cas_all_rise;
    logic [BANK_W-1:0]   w_fall_bank;
    logic                w_open_row, w_cbr, w_access, w_err_set, w_overdue_set;
    logic [IDX_W-1:0]    w_idx;
    logic [31:0]         w_rd_data;

    assign w_ras_fall     = r_ras_prev & ~i_ras;
    assign w_ras_rise     = ~r_ras_prev & i_ras;
    assign w_cas_fall     = r_cas_prev & ~i_cas;
    assign w_cas_all_high = &i_cas;
    assign w_cas_all_rise = w_cas_all_high & ~(&r_cas_prev);
    assign w_bank_onehot  = BANKS'(1) << r_bank;
    assign w_idx          = {r_bank, r_row, i_ma[COL_BITS-1:0]};
    assign w_rd_data      = r_mem[w_idx];
    assign w_overdue_set  = r_ref_seen && !w_cbr && (r_interval == IVL_W'(REFRESH_LIMIT - 1));

    // Encode the falling RAS line into a bank number.
    always_comb begin
        w_fall_bank = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (w_ras_fall[b]) w_fall_bank = BANK_W'(b);
        end
    end

    // Next-state and strobe-protocol decode.
    always_comb begin
        w_next_state = r_state;
        w_open_row   = 1'b0;
        w_cbr        = 1'b0;
        w_access     = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_ras_fall) begin
                    if (!w_cas_all_high) begin
                        w_cbr        = 1'b1;
                        w_next_state = ST_REFRESH;
                    end else if ($countones(w_ras_fall) == 1) begin
                        w_open_row   = 1'b1;
                        w_next_state = ST_ROW_OPEN;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end else if (r_cas_only && w_cas_all_high) begin
                    // CAS went low and came back without any RAS: not a CBR.
                    w_err_set = 1'b1;
                end
            end
            ST_ROW_OPEN, ST_COL_ACTIVE: begin
                if (|(w_ras_fall & ~w_bank_onehot)) w_err_set = 1'b1;
                if (w_ras_rise[r_bank]) begin
                    w_next_state = ST_IDLE;
                    if (r_tras < TRAS_W'(TRAS_MIN)) w_err_set = 1'b1;
                    if (!w_cas_all_high) w_err_set = 1'b1;
                end else if (r_state == ST_ROW_OPEN && |w_cas_fall) begin
                    w_access     = 1'b1;
                    w_next_state = ST_COL_ACTIVE;
                end else if (r_state == ST_COL_ACTIVE && w_cas_all_high) begin
                    w_next_state = ST_ROW_OPEN;
                end
            end
            ST_REFRESH: begin
                if (&i_ras) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, strobe history, open-row latches and RAS-low timer.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_ras_prev <= '1;
            r_cas_prev <= '1;
            r_bank     <= '0;
            r_row      <= '0;
            r_tras     <= '0;
            r_cas_only <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ras_prev <= i_ras;
            r_cas_prev <= i_cas;
            if (w_open_row) begin
                r_bank <= w_fall_bank;
                r_row  <= i_ma[ROW_BITS-1:0];
            end
            if (w_open_row) r_tras <= TRAS_W'(1);
            else if (r_tras != TRAS_W'(TRAS_MIN)) r_tras <= r_tras + 1'b1;
            if (r_state != ST_IDLE || |w_ras_fall) r_cas_only <= 1'b0;
            else if (|w_cas_fall && &i_ras) r_cas_only <= 1'b1;
            else if (w_cas_all_high) r_cas_only <= 1'b0;
        end
    end

    // Refresh bookkeeping and sticky error flags; a same-cycle set beats err_clear.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_refresh_count <= '0;
            r_interval      <= '0;
            r_ref_seen      <= 1'b0;
            r_overdue       <= 1'b0;
            r_perr          <= 1'b0;
        end else begin
            if (w_cbr) begin
                r_refresh_count <= r_refresh_count + 16'd1;
                r_interval      <= '0;
                r_ref_seen      <= 1'b1;
            end else if (r_ref_seen && r_interval != IVL_W'(REFRESH_LIMIT)) begin
                r_interval <= r_interval + 1'b1;
            end
            if (w_overdue_set) r_overdue <= 1'b1;
            else if (i_err_clear) r_overdue <= 1'b0;
            if (w_err_set) r_perr <= 1'b1;
            else if (i_err_clear) r_perr <= 1'b0;
        end
    end

    // Byte-lane write on the CAS fall that opens a column access.
    always_ff @(posedge i_clock) begin
        if (w_access && !i_we) begin
            for (int k = 0; k < LANES; k++) begin
                if (!i_cas[k]) r_mem[w_idx][LANE_BITS*k +: LANE_BITS] <= i_wdata[LANE_BITS*k +: LANE_BITS];
            end
        end
    end

    simm_read_pipe #(
        .DEPTH (READ_LATENCY),
        .WIDTH (32)
    ) u_read_pipe (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_flush (w_cas_all_rise),
        .i_valid (w_access & i_we),
        .i_data  (w_rd_data),
        .o_valid (o_rdata_valid),
        .o_data  (o_rdata)
    );

    assign o_refresh_count   = r_refresh_count;
    assign o_refresh_overdue = r_overdue;
    assign o_protocol_error  = r_perr;

endmodule

// File: tb/tb_simm_dram_responder.sv
// tb/tb_simm_dram_responder.sv - directed self-checking bench for simm_dram_responder
module tb_simm_dram_responder;
    import simm_pkg::*;

    localparam int READ_LATENCY  = 2;
    localparam int REFRESH_LIMIT = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ras, cas, ma;
    logic        we, err_clear;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid, overdue, perr;
    logic [15:0] refresh_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    simm_dram_responder #(
        .ROW_BITS(4), .COL_BITS(4), .BANKS(4),
        .READ_LATENCY(READ_LATENCY), .TRAS_MIN(3), .REFRESH_LIMIT(REFRESH_LIMIT)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_ras(ras), .i_cas(cas), .i_we(we),
        .i_ma(ma), .i_wdata(wdata), .o_rdata(rdata), .o_rdata_valid(rdata_valid),
        .o_refresh_count(refresh_count), .o_refresh_overdue(overdue),
        .o_protocol_error(perr), .i_err_clear(err_clear)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1; cyc(1); err_clear = 1'b0;
    endtask

    task automatic do_write(input int bank, input logic [3:0] row, input logic [3:0] col,
                            input logic [31:0] data, input logic [3:0] lanes);
        ma = row; ras[bank] = 1'b0; cyc(1);
        ma = col; we = 1'b0; wdata = data; cas = lanes; cyc(2);
        cas = 4'hF; we = 1'b1; cyc(1);
        ras = 4'hF; cyc(1);
    endtask

    task automatic do_read(input int bank, input logic [3:0] row, input logic [3:0] col,
                           output logic [31:0] data, output int lat,
                           output logic valid_after, output logic [31:0] data_after);
        ma = row; ras[bank] = 1'b0; cyc(1);
        ma = col; we = 1'b1; cas = 4'h0; cyc(1);
        lat = -1; data = '0;
        for (int k = 0; k < 6; k++) begin
            if (rdata_valid && lat < 0) begin lat = k; data = rdata; end
            cyc(1);
        end
        cas = 4'hF; cyc(1);
        valid_after = rdata_valid; data_after = rdata;
        ras = 4'hF; cyc(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ras = 4'hF; cas = 4'hF; we = 1'b1; ma = '0; wdata = '0; err_clear = 1'b0;
        cyc(2);
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        n_checks++; if (rdata_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", rdata_valid); end
        n_checks++; if (refresh_count !== 16'h0) begin n_errors++; $display("FAIL reset_refcnt got %0d want 0", refresh_count); end
        n_checks++; if (overdue !== 1'b0 || perr !== 1'b0) begin n_errors++; $display("FAIL reset_flags got %b%b want 00", overdue, perr); end
        n_checks++; if (dut.r_state !== ST_IDLE) begin n_errors++; $display("FAIL reset_state got %0d want %0d", dut.r_state, ST_IDLE); end
        rst_n = 1'b1; cyc(1);
    endtask

    task automatic test_write_read();
        logic [31:0] d, da; int lat; logic va;
        do_write(0, 4'd3, 4'd5, 32'hDEADBEEF, 4'h0);
        do_read(0, 4'd3, 4'd5, d, lat, va, da);
        n_checks++; if (d !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wr_rd_data got %h want deadbeef", d); end
        n_checks++; if (lat != READ_LATENCY) begin n_errors++; $display("FAIL wr_rd_latency got %0d want %0d", lat, READ_LATENCY); end
        n_checks++; if (va !== 1'b0) begin n_errors++; $display("FAIL valid_drop got %b want 0", va); end
        n_checks++; if (da !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rdata_hold got %h want deadbeef", da); end
        n_checks++; if (perr !== 1'b0) begin n_errors++; $display("FAIL wr_rd_noerr got %b want 0", perr); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d, da; int lat; logic va;
        do_write(2, 4'd1, 4'd7, 32'hAABBCCDD, 4'h0);
        do_write(2, 4'd1, 4'd7, 32'h11223344, 4'b1100);
        do_read(2, 4'd1, 4'd7, d, lat, va, da);
        n_checks++; if (d !== 32'hAABB3344) begin n_errors++; $display("FAIL byte_lanes got %h want aabb3344", d); end
    endtask

    task automatic test_page_mode();
        ma = 4'd6; ras[1] = 1'b0; cyc(1);
        for (int c = 0; c < 3; c++) begin
            ma = 4'(c); wdata = 32'(c + 1); we = 1'b0; cas = 4'h0; cyc(1);
            cas = 4'hF; we = 1'b1; cyc(1);
            n_checks++; if (dut.r_state !== ST_ROW_OPEN) begin n_errors++; $display("FAIL page_wr_state col %0d got %0d want %0d", c, dut.r_state, ST_ROW_OPEN); end
        end
        ras = 4'hF; cyc(1);
        ma = 4'd6; ras[1] = 1'b0; cyc(1);
        for (int c = 0; c < 3; c++) begin
            ma = 4'(c); cas = 4'h0; cyc(1 + READ_LATENCY);
            n_checks++; if (rdata_valid !== 1'b1 || rdata !== 32'(c + 1)) begin n_errors++; $display("FAIL page_rd col %0d got %b/%h want 1/%h", c, rdata_valid, rdata, 32'(c + 1)); end
            cas = 4'hF; cyc(1);
            n_checks++; if (dut.r_state !== ST_ROW_OPEN) begin n_errors++; $display("FAIL page_rd_state col %0d got %0d want %0d", c, dut.r_state, ST_ROW_OPEN); end
        end
        ras = 4'hF; cyc(1);
        n_checks++; if (perr !== 1'b0) begin n_errors++; $display("FAIL page_noerr got %b want 0", perr); end
    endtask

    task automatic test_cbr();
        logic [31:0] d, da; int lat; logic va; int c0;
        cas = 4'h0; cyc(1);
        ras = 4'h0; cyc(1);
        c0 = cyc_cnt;
        n_checks++; if (refresh_count !== 16'd1) begin n_errors++; $display("FAIL cbr_count got %0d want 1", refresh_count); end
        cyc(2); ras = 4'hF; cyc(1); cas = 4'hF; cyc(1);
        n_checks++; if (perr !== 1'b0) begin n_errors++; $display("FAIL cbr_noerr got %b want 0", perr); end
        do_read(0, 4'd3, 4'd5, d, lat, va, da);
        n_checks++; if (d !== 32'hDEADBEEF) begin n_errors++; $display("FAIL cbr_array got %h want deadbeef", d); end
        while (cyc_cnt < c0 + REFRESH_LIMIT - 1) cyc(1);
        n_checks++; if (overdue !== 1'b0) begin n_errors++; $display("FAIL overdue_early got %b want 0", overdue); end
        cyc(1);
        n_checks++; if (overdue !== 1'b1) begin n_errors++; $display("FAIL overdue_set got %b want 1", overdue); end
        pulse_clear(); cyc(2);
        n_checks++; if (overdue !== 1'b0) begin n_errors++; $display("FAIL overdue_clear got %b want 0", overdue); end
    endtask

    task automatic test_violations();
        logic [31:0] d, da; int lat; logic va;
        cas = 4'h0; cyc(1); cas = 4'hF; cyc(1);
        n_checks++; if (perr !== 1'b1) begin n_errors++; $display("FAIL cas_only got %b want 1", perr); end
        pulse_clear();
        n_checks++; if (perr !== 1'b0) begin n_errors++; $display("FAIL err_clear got %b want 0", perr); end
        ma = 4'd0; ras[0] = 1'b0; cyc(3); ras = 4'hF; cyc(1);
        n_checks++; if (perr !== 1'b0) begin n_errors++; $display("FAIL tras_ok got %b want 0", perr); end
        ras[0] = 1'b0; cyc(2); ras = 4'hF; cyc(1);
        n_checks++; if (perr !== 1'b1) begin n_errors++; $display("FAIL tras_short got %b want 1", perr); end
        pulse_clear();
        ma = 4'd3; ras[0] = 1'b0; cyc(1);
        ma = 4'd5; we = 1'b1; cas = 4'h0; cyc(1);
        ras[1] = 1'b0; cyc(1);
        n_checks++; if (perr !== 1'b1) begin n_errors++; $display("FAIL second_bank got %b want 1", perr); end
        cyc(1);
        n_checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL second_bank_rd got %b/%h want 1/deadbeef", rdata_valid, rdata); end
        cas = 4'hF; cyc(1); ras = 4'hF; cyc(1);
        pulse_clear();
        do_read(0, 4'd3, 4'd5, d, lat, va, da);
        n_checks++; if (d !== 32'hDEADBEEF) begin n_errors++; $display("FAIL bank0_intact got %h want deadbeef", d); end
    endtask

    task automatic test_reset_mid_read();
        logic seen;
        ma = 4'd3; ras[0] = 1'b0; cyc(1);
        ma = 4'd5; we = 1'b1; cas = 4'h0; cyc(1);
        rst_n = 1'b0; ras = 4'hF; cas = 4'hF; cyc(1);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (rdata_valid) seen = 1'b1;
            cyc(1);
        end
        n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL rst_read_dropped got %b want 0", seen); end
        n_checks++; if (refresh_count !== 16'd0) begin n_errors++; $display("FAIL rst_refcnt got %0d want 0", refresh_count); end
        n_checks++; if (dut.r_state !== ST_IDLE) begin n_errors++; $display("FAIL rst_state got %0d want %0d", dut.r_state, ST_IDLE); end
        n_checks++; if (rdata !== 32'h0 || perr !== 1'b0) begin n_errors++; $display("FAIL rst_outputs got %h/%b want 0/0", rdata, perr); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_page_mode();
        test_cbr();
        test_violations();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
